// File: rtl/register_file_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : register_file_mp_if
// Brief    : Pipeline-to-register-file bus (three reads, two writes,
//            load scoreboard control, stall and debug taps).
// Revision : 1.0
// ============================================================================
interface register_file_mp_if #(
    parameter int W      = 32,
    parameter int AW     = 4,
    parameter int N_REGS = 16
);
    logic [AW-1:0]     i_A1, i_A2, i_A3;
    logic              i_RE1, i_RE2, i_RE3;
    logic              i_WEA;
    logic [AW-1:0]     i_WAA;
    logic [W-1:0]      i_WDA;
    logic              i_WEB;
    logic [AW-1:0]     i_WAB;
    logic [W-1:0]      i_WDB;
    logic              i_busy_set;
    logic [AW-1:0]     i_busy_addr;
    logic [W-1:0]      i_R15;
    logic [W-1:0]      o_RD1, o_RD2, o_RD3;
    logic              o_stall;
    logic [N_REGS-1:0] o_busy;
    logic [W-1:0]      o_test_r0, o_test_r1, o_test_r2, o_test_r3;

    modport master (
        output i_A1, i_A2, i_A3, i_RE1, i_RE2, i_RE3,
        output i_WEA, i_WAA, i_WDA, i_WEB, i_WAB, i_WDB,
        output i_busy_set, i_busy_addr, i_R15,
        input  o_RD1, o_RD2, o_RD3, o_stall, o_busy,
        input  o_test_r0, o_test_r1, o_test_r2, o_test_r3
    );

    modport slave (
        input  i_A1, i_A2, i_A3, i_RE1, i_RE2, i_RE3,
        input  i_WEA, i_WAA, i_WDA, i_WEB, i_WAB, i_WDB,
        input  i_busy_set, i_busy_addr, i_R15,
        output o_RD1, o_RD2, o_RD3, o_stall, o_busy,
        output o_test_r0, o_test_r1, o_test_r2, o_test_r3
    );
endinterface
`default_nettype wire

// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : register_file_mp
// Brief    : ARM register file, 3 combinational reads, ALU + load write ports,
//            load busy scoreboard with stall. Optional macro REGFILE_BYPASS_EN
//            enables write-to-read forwarding.
// Revision : 1.0
// ============================================================================
module register_file_mp #(
    parameter int W      = 32,
    parameter int AW     = 4,
    parameter int N_REGS = 16,
    parameter int PC_IDX = 15
) (
    input  wire logic         clk,
    input  wire logic         rst,
    register_file_mp_if.slave bus
);
    localparam int            c_DEPTH   = 2 ** AW;
    localparam logic [AW-1:0] c_PC_ADDR = AW'(PC_IDX);

    // Full address space is decoded; unstored slots read as zero and never go busy.
    logic [W-1:0]       w_regs [c_DEPTH];
    logic [c_DEPTH-1:0] w_busy;
    logic [c_DEPTH-1:0] w_valid;

    genvar r;
    generate
        for (r = 0; r < c_DEPTH; r++) begin : g_reg
            if (r < N_REGS && r != PC_IDX) begin : g_store
                logic         w_wa_hit, w_wb_hit, w_set_hit;
                logic [W-1:0] r_data_q;
                logic         r_busy_q;
                logic         w_busy_d;

                assign w_wa_hit  = bus.i_WEA && (bus.i_WAA == AW'(r));
                assign w_wb_hit  = bus.i_WEB && (bus.i_WAB == AW'(r));
                assign w_set_hit = bus.i_busy_set && (bus.i_busy_addr == AW'(r));
                // A newly issued load outranks the completion of an older one.
                assign w_busy_d  = w_set_hit | (r_busy_q & ~w_wb_hit);

                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_data_q <= '0;
                        r_busy_q <= 1'b0;
                    end else begin
                        if (w_wa_hit)
                            r_data_q <= bus.i_WDA;
                        else if (w_wb_hit)
                            r_data_q <= bus.i_WDB;
                        r_busy_q <= w_busy_d;
                    end
                end

                assign w_regs[r]  = r_data_q;
                assign w_busy[r]  = r_busy_q;
                assign w_valid[r] = 1'b1;
            end else begin : g_none
                assign w_regs[r]  = '0;
                assign w_busy[r]  = 1'b0;
                assign w_valid[r] = 1'b0;
            end
        end
    endgenerate

    logic [AW-1:0] w_ra [3];
    logic [2:0]    w_re;

    assign w_ra[0] = bus.i_A1;
    assign w_ra[1] = bus.i_A2;
    assign w_ra[2] = bus.i_A3;
    assign w_re    = {bus.i_RE3, bus.i_RE2, bus.i_RE1};

    genvar p;
    generate
        for (p = 0; p < 3; p++) begin : g_rport
            logic [W-1:0] w_rd;
            logic         w_stall;

            always_comb begin
                w_rd = w_regs[w_ra[p]];
`ifdef REGFILE_BYPASS_EN
                if (w_valid[w_ra[p]]) begin
                    if (bus.i_WEA && bus.i_WAA == w_ra[p])
                        w_rd = bus.i_WDA;
                    else if (bus.i_WEB && bus.i_WAB == w_ra[p])
                        w_rd = bus.i_WDB;
                end
`endif
                if (w_ra[p] == c_PC_ADDR)
                    w_rd = bus.i_R15;
            end

`ifdef REGFILE_BYPASS_EN
            // The completing load is forwarded, so it no longer needs to stall.
            assign w_stall = w_re[p] && w_busy[w_ra[p]]
                             && !(bus.i_WEB && bus.i_WAB == w_ra[p]);
`else
            assign w_stall = w_re[p] && w_busy[w_ra[p]];
`endif
        end
    endgenerate

    assign bus.o_RD1     = g_rport[0].w_rd;
    assign bus.o_RD2     = g_rport[1].w_rd;
    assign bus.o_RD3     = g_rport[2].w_rd;
    assign bus.o_stall   = g_rport[0].w_stall | g_rport[1].w_stall | g_rport[2].w_stall;
    assign bus.o_busy    = w_busy[N_REGS-1:0];
    assign bus.o_test_r0 = w_regs[0];
    assign bus.o_test_r1 = w_regs[1];
    assign bus.o_test_r2 = w_regs[2];
    assign bus.o_test_r3 = w_regs[3];
endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_register_file_mp
// Brief    : Scoreboard bench for register_file_mp (both REGFILE_BYPASS_EN builds).
// Revision : 1.0
// ============================================================================
module tb_register_file_mp;
    localparam int W      = 32;
    localparam int AW     = 4;
    localparam int N_REGS = 16;
    localparam int PC_IDX = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    register_file_mp_if #(.W(W), .AW(AW), .N_REGS(N_REGS)) bus ();

    register_file_mp #(.W(W), .AW(AW), .N_REGS(N_REGS), .PC_IDX(PC_IDX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] exp_q [$];
    logic [W-1:0] e;
    logic [W-1:0] m_regs [N_REGS];
    logic [N_REGS-1:0] m_busy;

    function automatic bit valid(logic [AW-1:0] a);
        return int'(a) < N_REGS && int'(a) != PC_IDX;
    endfunction

    function automatic logic [W-1:0] exp_rd(logic [AW-1:0] a);
        if (int'(a) == PC_IDX) return bus.i_R15;
        if (!valid(a)) return '0;
`ifdef REGFILE_BYPASS_EN
        if (bus.i_WEA && bus.i_WAA == a) return bus.i_WDA;
        if (bus.i_WEB && bus.i_WAB == a) return bus.i_WDB;
`endif
        return m_regs[a];
    endfunction

    function automatic bit port_stall(bit re, logic [AW-1:0] a);
        if (!re || !valid(a) || !m_busy[a]) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (bus.i_WEB && bus.i_WAB == a) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic bit exp_stall();
        return port_stall(bus.i_RE1, bus.i_A1) | port_stall(bus.i_RE2, bus.i_A2)
             | port_stall(bus.i_RE3, bus.i_A3);
    endfunction

    // Reference state update for the edge that ends the current cycle.
    task automatic model_edge();
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_busy = '0;
            return;
        end
        if (bus.i_WEB && valid(bus.i_WAB)) begin
            m_busy[bus.i_WAB] = 1'b0;
            if (!(bus.i_WEA && bus.i_WAA == bus.i_WAB)) m_regs[bus.i_WAB] = bus.i_WDB;
        end
        if (bus.i_WEA && valid(bus.i_WAA)) m_regs[bus.i_WAA] = bus.i_WDA;
        if (bus.i_busy_set && valid(bus.i_busy_addr)) m_busy[bus.i_busy_addr] = 1'b1;
    endtask

    task automatic drive_idle();
        bus.i_A1 = '0; bus.i_A2 = '0; bus.i_A3 = '0;
        bus.i_RE1 = 1'b0; bus.i_RE2 = 1'b0; bus.i_RE3 = 1'b0;
        bus.i_WEA = 1'b0; bus.i_WAA = '0; bus.i_WDA = '0;
        bus.i_WEB = 1'b0; bus.i_WAB = '0; bus.i_WDB = '0;
        bus.i_busy_set = 1'b0; bus.i_busy_addr = '0;
        bus.i_R15 = 32'h0000_0108;
    endtask

    task automatic cyc_start();
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    task automatic drive_random(bit with_rst);
        bus.i_A1 = AW'($urandom_range(0, 15));
        bus.i_A2 = AW'($urandom_range(0, 15));
        bus.i_A3 = AW'($urandom_range(0, 15));
        bus.i_RE1 = 1'($urandom); bus.i_RE2 = 1'($urandom); bus.i_RE3 = 1'($urandom);
        bus.i_WEA = 1'($urandom); bus.i_WAA = AW'($urandom_range(0, 15)); bus.i_WDA = $urandom;
        bus.i_WEB = 1'($urandom); bus.i_WAB = AW'($urandom_range(0, 15)); bus.i_WDB = $urandom;
        bus.i_busy_set = ($urandom_range(0, 2) == 0);
        bus.i_busy_addr = AW'($urandom_range(0, 15));
        if (!with_rst) bus.i_R15 = $urandom;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            cyc_start(); rst = 1'b0; drive_random(1'b0);
            @(negedge clk); model_edge();
        end
        for (int i = 0; i < 2; i++) begin
            cyc_start(); rst = 1'b1; drive_random(1'b1);
            @(negedge clk); model_edge();
        end
        cyc_start(); rst = 1'b0; bus.i_A1 = 4'd15;
        exp_q.push_back('0); exp_q.push_back('0); exp_q.push_back('0); exp_q.push_back('0);
        exp_q.push_back('0); exp_q.push_back(32'h0000_0108); exp_q.push_back('0);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (bus.o_test_r0 !== e) begin failures++; $display("FAIL reset_r0 got=%h exp=%h", bus.o_test_r0, e); end
        e = exp_q.pop_front(); checks++;
        if (bus.o_test_r1 !== e) begin failures++; $display("FAIL reset_r1 got=%h exp=%h", bus.o_test_r1, e); end
        e = exp_q.pop_front(); checks++;
        if (bus.o_test_r2 !== e) begin failures++; $display("FAIL reset_r2 got=%h exp=%h", bus.o_test_r2, e); end
        e = exp_q.pop_front(); checks++;
        if (bus.o_test_r3 !== e) begin failures++; $display("FAIL reset_r3 got=%h exp=%h", bus.o_test_r3, e); end
        e = exp_q.pop_front(); checks++;
        if (W'(bus.o_busy) !== e) begin failures++; $display("FAIL reset_busy got=%h exp=%h", bus.o_busy, e); end
        e = exp_q.pop_front(); checks++;
        if (bus.o_RD1 !== e) begin failures++; $display("FAIL reset_rd1_pc got=%h exp=%h", bus.o_RD1, e); end
        e = exp_q.pop_front(); checks++;
        if (W'(bus.o_stall) !== e) begin failures++; $display("FAIL reset_stall got=%h exp=%h", bus.o_stall, e); end
        model_edge();
    endtask

    task automatic test_basic();
        cyc_start();
        bus.i_WEA = 1'b1; bus.i_WAA = 4'd5; bus.i_WDA = 32'hDEAD_BEEF;
        @(negedge clk); model_edge();
        cyc_start();
        bus.i_A2 = 4'd5; bus.i_A1 = 4'd15;
        bus.i_WEA = 1'b1; bus.i_WAA = 4'd15; bus.i_WDA = 32'h0000_1234;
        exp_q.push_back(32'hDEAD_BEEF); exp_q.push_back(32'h0000_0108);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (bus.o_RD2 !== e) begin failures++; $display("FAIL basic_rd2 got=%h exp=%h", bus.o_RD2, e); end
        e = exp_q.pop_front(); checks++;
        if (bus.o_RD1 !== e) begin failures++; $display("FAIL basic_pc_write got=%h exp=%h", bus.o_RD1, e); end
        model_edge();
        cyc_start();
        bus.i_A1 = 4'd15; bus.i_R15 = 32'h0000_0208;
        exp_q.push_back(32'h0000_0208);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (bus.o_RD1 !== e) begin failures++; $display("FAIL basic_pc_dropped got=%h exp=%h", bus.o_RD1, e); end
        model_edge();
    endtask

    task automatic test_collision();
        cyc_start();
        bus.i_WEA = 1'b1; bus.i_WAA = 4'd3; bus.i_WDA = 32'h11;
        bus.i_WEB = 1'b1; bus.i_WAB = 4'd3; bus.i_WDB = 32'h22;
        @(negedge clk); model_edge();
        cyc_start();
        bus.i_A3 = 4'd3;
        exp_q.push_back(32'h11); exp_q.push_back(32'h11);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (bus.o_test_r3 !== e) begin failures++; $display("FAIL collision_r3 got=%h exp=%h", bus.o_test_r3, e); end
        e = exp_q.pop_front(); checks++;
        if (bus.o_RD3 !== e) begin failures++; $display("FAIL collision_rd3 got=%h exp=%h", bus.o_RD3, e); end
        model_edge();
    endtask

    task automatic test_scoreboard();
        cyc_start();
        bus.i_busy_set = 1'b1; bus.i_busy_addr = 4'd7;
        @(negedge clk); model_edge();
        cyc_start();
        bus.i_A1 = 4'd7; bus.i_RE1 = 1'b0; bus.i_busy_set = 1'b1; bus.i_busy_addr = 4'd15;
        exp_q.push_back(32'd0);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (W'(bus.o_stall) !== e) begin failures++; $display("FAIL sb_re_off got=%h exp=%h", bus.o_stall, e); end
        model_edge();
        cyc_start();
        bus.i_A1 = 4'd7; bus.i_RE1 = 1'b1; bus.i_A3 = 4'd15; bus.i_RE3 = 1'b1;
        exp_q.push_back(32'd1); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (W'(bus.o_stall) !== e) begin failures++; $display("FAIL sb_stall got=%h exp=%h", bus.o_stall, e); end
        e = exp_q.pop_front(); checks++;
        if (W'(bus.o_busy[7]) !== e) begin failures++; $display("FAIL sb_busy7 got=%h exp=%h", bus.o_busy[7], e); end
        e = exp_q.pop_front(); checks++;
        if (W'(bus.o_busy[15]) !== e) begin failures++; $display("FAIL sb_busy_pc got=%h exp=%h", bus.o_busy[15], e); end
        model_edge();
        cyc_start();
        bus.i_A1 = 4'd7; bus.i_RE1 = 1'b1;
        bus.i_WEB = 1'b1; bus.i_WAB = 4'd7; bus.i_WDB = 32'h55;
`ifdef REGFILE_BYPASS_EN
        exp_q.push_back(32'd0); exp_q.push_back(32'h55);
`else
        exp_q.push_back(32'd1); exp_q.push_back(32'd0);
`endif
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (W'(bus.o_stall) !== e) begin failures++; $display("FAIL sb_complete_stall got=%h exp=%h", bus.o_stall, e); end
        e = exp_q.pop_front(); checks++;
        if (bus.o_RD1 !== e) begin failures++; $display("FAIL sb_complete_rd1 got=%h exp=%h", bus.o_RD1, e); end
        model_edge();
        cyc_start();
        bus.i_A1 = 4'd7; bus.i_RE1 = 1'b1;
        exp_q.push_back(32'd0); exp_q.push_back(32'h55); exp_q.push_back(32'd0);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (W'(bus.o_stall) !== e) begin failures++; $display("FAIL sb_after_stall got=%h exp=%h", bus.o_stall, e); end
        e = exp_q.pop_front(); checks++;
        if (bus.o_RD1 !== e) begin failures++; $display("FAIL sb_after_rd1 got=%h exp=%h", bus.o_RD1, e); end
        e = exp_q.pop_front(); checks++;
        if (W'(bus.o_busy[7]) !== e) begin failures++; $display("FAIL sb_after_busy7 got=%h exp=%h", bus.o_busy[7], e); end
        model_edge();
    endtask

    task automatic test_race();
        cyc_start();
        bus.i_busy_set = 1'b1; bus.i_busy_addr = 4'd2;
        @(negedge clk); model_edge();
        cyc_start();
        bus.i_WEB = 1'b1; bus.i_WAB = 4'd2; bus.i_WDB = 32'h77;
        bus.i_busy_set = 1'b1; bus.i_busy_addr = 4'd2;
        @(negedge clk); model_edge();
        cyc_start();
        bus.i_A2 = 4'd2; bus.i_RE2 = 1'b1;
        exp_q.push_back(32'd1); exp_q.push_back(32'd1); exp_q.push_back(32'h77);
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (W'(bus.o_busy[2]) !== e) begin failures++; $display("FAIL race_busy2 got=%h exp=%h", bus.o_busy[2], e); end
        e = exp_q.pop_front(); checks++;
        if (W'(bus.o_stall) !== e) begin failures++; $display("FAIL race_stall got=%h exp=%h", bus.o_stall, e); end
        e = exp_q.pop_front(); checks++;
        if (bus.o_test_r2 !== e) begin failures++; $display("FAIL race_r2 got=%h exp=%h", bus.o_test_r2, e); end
        model_edge();
        cyc_start();
        bus.i_WEB = 1'b1; bus.i_WAB = 4'd2; bus.i_WDB = 32'h78;
        @(negedge clk); model_edge();
    endtask

    task automatic test_bypass();
        cyc_start();
        bus.i_WEA = 1'b1; bus.i_WAA = 4'd1; bus.i_WDA = 32'hA5A5_A5A5;
        bus.i_A1 = 4'd1; bus.i_A2 = 4'd1; bus.i_A3 = 4'd1;
        for (int k = 0; k < 3; k++) begin
`ifdef REGFILE_BYPASS_EN
            exp_q.push_back(32'hA5A5_A5A5);
`else
            exp_q.push_back(m_regs[1]);
`endif
        end
        @(negedge clk);
        e = exp_q.pop_front(); checks++;
        if (bus.o_RD1 !== e) begin failures++; $display("FAIL bypass_rd1 got=%h exp=%h", bus.o_RD1, e); end
        e = exp_q.pop_front(); checks++;
        if (bus.o_RD2 !== e) begin failures++; $display("FAIL bypass_rd2 got=%h exp=%h", bus.o_RD2, e); end
        e = exp_q.pop_front(); checks++;
        if (bus.o_RD3 !== e) begin failures++; $display("FAIL bypass_rd3 got=%h exp=%h", bus.o_RD3, e); end
        model_edge();
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            cyc_start();
            drive_random(1'b0);
            exp_q.push_back(exp_rd(bus.i_A1));
            exp_q.push_back(exp_rd(bus.i_A2));
            exp_q.push_back(exp_rd(bus.i_A3));
            exp_q.push_back(W'(exp_stall()));
            exp_q.push_back(W'(m_busy));
            @(negedge clk);
            e = exp_q.pop_front(); checks++;
            if (bus.o_RD1 !== e) begin failures++; $display("FAIL rand_rd1 n=%0d got=%h exp=%h", n, bus.o_RD1, e); end
            e = exp_q.pop_front(); checks++;
            if (bus.o_RD2 !== e) begin failures++; $display("FAIL rand_rd2 n=%0d got=%h exp=%h", n, bus.o_RD2, e); end
            e = exp_q.pop_front(); checks++;
            if (bus.o_RD3 !== e) begin failures++; $display("FAIL rand_rd3 n=%0d got=%h exp=%h", n, bus.o_RD3, e); end
            e = exp_q.pop_front(); checks++;
            if (W'(bus.o_stall) !== e) begin failures++; $display("FAIL rand_stall n=%0d got=%h exp=%h", n, bus.o_stall, e); end
            e = exp_q.pop_front(); checks++;
            if (W'(bus.o_busy) !== e) begin failures++; $display("FAIL rand_busy n=%0d got=%h exp=%h", n, bus.o_busy, e); end
            model_edge();
        end
    endtask

    initial begin
        drive_idle();
        rst = 1'b1;
        foreach (m_regs[i]) m_regs[i] = '0;
        m_busy = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_collision();
        test_scoreboard();
        test_race();
        test_bypass();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
